// File: rtl/des_pkg.sv
// DES constant tables and bit-permutation helpers shared by the DES
// encrypt and decrypt datapaths. Tables use the textbook 1-based
// numbering, where bit 1 is the MSB of the operand.
package des_pkg;

    // FSM encodings (kept as plain constants for the legacy blocks)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned NUM_ROUNDS = 16;

    localparam int unsigned IP [0:63] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP [0:63] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int unsigned E [0:47] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int unsigned P [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int unsigned PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int unsigned SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Flattened as [box][row*16 + col]
    localparam int unsigned SBOX [0:7][0:63] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
           0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
           4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
           3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
           0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
           1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
           3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
           4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
           9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
           4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
           1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
           6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
           1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
           7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
           2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] permute_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] permute_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] permute_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] permute_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P[5'(i)])];
        return y;
    endfunction

    // Parity bits (8, 16, ..., 64) never appear in PC1, so they drop out here
    function automatic logic [55:0] permute_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] permute_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2[6'(i)])];
        return y;
    endfunction

    // Row comes from the outer bits, column from the inner four
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
        return 4'(SBOX[box][{six[5], six[0], six[4:1]}]);
    endfunction

endpackage

// File: rtl/des_encrypt_if.sv
// Handshake/data bundle for the DES encrypt block.
//   message   : plaintext block (bit 63 = DES bit 1)
//   DESkey    : 64-bit key including parity bits
//   enable    : start request, honoured in IDLE
//   ack       : consumer acknowledge, honoured in DONE
//   encrypted : registered ciphertext
//   done      : high while encrypted is valid and unacknowledged
interface des_encrypt_if;
    logic [63:0] message;
    logic [63:0] DESkey;
    logic        enable;
    logic        ack;
    logic [63:0] encrypted;
    logic        done;

    modport master (output message, DESkey, enable, ack, input encrypted, done);
    modport slave  (input message, DESkey, enable, ack, output encrypted, done);
endinterface

// File: rtl/des_round.sv
// One combinational DES Feistel round including the key-schedule step.
//   l, r   : current halves        l_o, r_o : halves after this round
//   c, d   : key halves before     c_o, d_o : key halves after rotation
//   rnd    : zero-based round index (0 = round 1)
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic [3:0]  rnd,
    output logic [31:0] l_o,
    output logic [31:0] r_o,
    output logic [27:0] c_o,
    output logic [27:0] d_o
);

    function automatic logic [31:0] feistel(input logic [31:0] half, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = permute_e(half) ^ k;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            s = {s[27:0], sbox_lookup(3'(i), x[47:42])};
            x = {x[41:0], 6'b0};
        end
        return permute_p(s);
    endfunction

    logic [47:0] subkey;

    always_comb begin
        if (SHIFT[5'(rnd) + 5'd1] == 1) begin
            c_o = {c[26:0], c[27]};
            d_o = {d[26:0], d[27]};
        end else begin
            c_o = {c[25:0], c[27:26]};
            d_o = {d[25:0], d[27:26]};
        end
        subkey = permute_pc2({c_o, d_o});
        l_o    = r;
        r_o    = l ^ feistel(r, subkey);
    end

endmodule

// File: rtl/des_encrypt.sv
// Iterative DES encryptor, ROUNDS_PER_CYCLE (1 or 2) rounds per clock.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : des_encrypt_if slave (message/DESkey/enable/ack in,
//           encrypted/done out, both registered)
module des_encrypt
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    des_encrypt_if.slave  bus
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
        $error("des_encrypt: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    logic [1:0]  state;
    logic [4:0]  rnd;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [63:0] enc_q;
    logic        done_q;

    logic [63:0] ip_msg;
    logic [55:0] cd_init;
    logic [4:0]  rnd_next;

    // Round chain: stage 0 is the register contents, stage N the result
    logic [31:0] sl [0:ROUNDS_PER_CYCLE];
    logic [31:0] sr [0:ROUNDS_PER_CYCLE];
    logic [27:0] sc [0:ROUNDS_PER_CYCLE];
    logic [27:0] sd [0:ROUNDS_PER_CYCLE];

    assign sl[0] = l_q;
    assign sr[0] = r_q;
    assign sc[0] = c_q;
    assign sd[0] = d_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        des_round u_round (
            .l   (sl[g]),
            .r   (sr[g]),
            .c   (sc[g]),
            .d   (sd[g]),
            .rnd (4'(rnd + 5'(g))),
            .l_o (sl[g+1]),
            .r_o (sr[g+1]),
            .c_o (sc[g+1]),
            .d_o (sd[g+1])
        );
    end

    assign ip_msg   = permute_ip(bus.message);
    assign cd_init  = permute_pc1(bus.DESkey);
    assign rnd_next = rnd + 5'(ROUNDS_PER_CYCLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            rnd    <= '0;
            l_q    <= '0;
            r_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            enc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        {l_q, r_q} <= ip_msg;
                        {c_q, d_q} <= cd_init;
                        rnd        <= '0;
                        state      <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    l_q <= sl[ROUNDS_PER_CYCLE];
                    r_q <= sr[ROUNDS_PER_CYCLE];
                    c_q <= sc[ROUNDS_PER_CYCLE];
                    d_q <= sd[ROUNDS_PER_CYCLE];
                    rnd <= rnd_next;
                    if (rnd_next == 5'(NUM_ROUNDS)) begin
                        // Halves are swapped before the final permutation
                        enc_q  <= permute_fp({sr[ROUNDS_PER_CYCLE], sl[ROUNDS_PER_CYCLE]});
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        done_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.encrypted = enc_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_des_encrypt.sv
// Directed bench for des_encrypt: one instance at 1 round/cycle and one at
// 2 rounds/cycle, both fed the same stimulus.
module tb_des_encrypt;
    import des_pkg::*;

    localparam logic [63:0] KEY_TB = 64'h133457799BBCDFF1;
    localparam logic [63:0] MSG_TB = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_TB  = 64'h85E813540F0AB405;
    localparam logic [63:0] CT_ZERO = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] KEY_WK = 64'h0E329232EA6D0D73;
    localparam logic [63:0] MSG_WK = 64'h8787878787878787;
    localparam logic [63:0] CT_WK  = 64'h0000000000000000;

    logic clk = 1'b0;
    logic reset;
    int unsigned checks = 0;
    int unsigned errors = 0;

    des_encrypt_if bus1 ();
    des_encrypt_if bus2 ();

    assign bus2.message = bus1.message;
    assign bus2.DESkey  = bus1.DESkey;
    assign bus2.enable  = bus1.enable;
    assign bus2.ack     = bus1.ack;

    des_encrypt #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    des_encrypt #(.ROUNDS_PER_CYCLE(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decryption; shift schedule written out independently
    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = permute_e(r) ^ k;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            s = {s[27:0], sbox_lookup(3'(i), x[47:42])};
            x = {x[41:0], 6'b0};
        end
        return permute_p(s);
    endfunction

    function automatic logic [63:0] ref_decrypt(input logic [63:0] ct, input logic [63:0] key);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] b;
        logic [31:0] l, r, t;
        logic [15:0] one_shift;
        one_shift = 16'b1000_0001_0000_0011;   // rounds 16, 9, 2, 1
        cd = permute_pc1(key);
        c = cd[55:28];
        d = cd[27:0];
        for (int unsigned i = 0; i < 16; i++) begin
            if (one_shift[i]) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end else begin
                c = {c[25:0], c[27:26]};
                d = {d[25:0], d[27:26]};
            end
            ks[i] = permute_pc2({c, d});
        end
        b = permute_ip(ct);
        l = b[63:32];
        r = b[31:0];
        for (int i = 15; i >= 0; i--) begin
            t = r;
            r = l ^ ref_f(r, ks[i]);
            l = t;
        end
        return permute_fp({r, l});
    endfunction

    task automatic start(input logic [63:0] msg, input logic [63:0] key);
        bus1.message = msg;
        bus1.DESkey  = key;
        bus1.enable  = 1'b1;
        @(posedge clk); #1;
        bus1.enable  = 1'b0;
    endtask

    // Counts edges until dut1 raises done (0 = timed out); optional input scrambling
    task automatic wait_done(input bit scramble, output int unsigned lat1, output int unsigned lat2);
        lat1 = 0;
        lat2 = 0;
        for (int unsigned n = 1; n <= 40; n++) begin
            if (scramble) begin
                bus1.message = {$urandom, $urandom};
                bus1.DESkey  = {$urandom, $urandom};
                bus1.enable  = n[0];
                bus1.ack     = (n < 7) ? ~n[0] : 1'b0;
            end
            @(posedge clk); #1;
            if (bus2.done && lat2 == 0) lat2 = n;
            if (bus1.done) begin
                lat1 = n;
                break;
            end
        end
        bus1.enable = 1'b0;
        bus1.ack    = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        bus1.ack = 1'b1;
        @(posedge clk); #1;
        bus1.ack = 1'b0;
        check({tag, "_done1"}, 64'(bus1.done), 64'd0);
        check({tag, "_done2"}, 64'(bus2.done), 64'd0);
    endtask

    initial begin
        int unsigned l1, l2;
        bit ok;
        logic [63:0] m, k;

        reset        = 1'b1;
        bus1.message = '0;
        bus1.DESkey  = '0;
        bus1.enable  = 1'b0;
        bus1.ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done1", 64'(bus1.done), 64'd0);
        check("rst_enc1", bus1.encrypted, 64'd0);
        check("rst_done2", 64'(bus2.done), 64'd0);
        check("rst_enc2", bus2.encrypted, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Zero vector, latency for both configurations
        start(64'd0, 64'd0);
        wait_done(1'b0, l1, l2);
        check("zero_enc1", bus1.encrypted, CT_ZERO);
        check("zero_lat1", 64'(l1), 64'd16);
        check("zero_enc2", bus2.encrypted, CT_ZERO);
        check("zero_lat2", 64'(l2), 64'd8);
        do_ack("zero_ack");
        @(posedge clk); #1;

        // Textbook vector with inputs churning during ROUND
        start(MSG_TB, KEY_TB);
        wait_done(1'b1, l1, l2);
        check("tb_enc1", bus1.encrypted, CT_TB);
        check("tb_lat1", 64'(l1), 64'd16);
        check("tb_enc2", bus2.encrypted, CT_TB);

        // No ack for 20 cycles: output held
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus1.done !== 1'b1 || bus1.encrypted !== CT_TB) ok = 1'b0;
        end
        check("hold_stable", 64'(ok), 64'd1);

        // enable+ack together in DONE: ack only, then restart from IDLE with enable held
        bus1.message = 64'd0;
        bus1.DESkey  = 64'd0;
        bus1.enable  = 1'b1;
        bus1.ack     = 1'b1;
        @(posedge clk); #1;
        bus1.ack = 1'b0;
        check("ackboth_done1", 64'(bus1.done), 64'd0);
        check("ackboth_enc1", bus1.encrypted, CT_TB);
        wait_done(1'b0, l1, l2);
        check("restart_lat1", 64'(l1), 64'd17);
        check("restart_lat2", 64'(l2), 64'd9);
        check("restart_enc1", bus1.encrypted, CT_ZERO);
        do_ack("restart_ack");
        @(posedge clk); #1;

        // Flipped parity bits must not matter
        start(MSG_TB, KEY_TB ^ 64'h0101010101010101);
        wait_done(1'b0, l1, l2);
        check("parity_enc1", bus1.encrypted, CT_TB);
        check("parity_enc2", bus2.encrypted, CT_TB);
        do_ack("parity_ack");
        @(posedge clk); #1;

        // Reset after round 7 discards the block
        start(MSG_WK, KEY_WK);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_done1", 64'(bus1.done), 64'd0);
        check("midrst_enc1", bus1.encrypted, 64'd0);
        check("midrst_enc2", bus2.encrypted, 64'd0);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus1.done !== 1'b0 || bus2.done !== 1'b0) ok = 1'b0;
        end
        check("midrst_idle", 64'(ok), 64'd1);
        start(MSG_WK, KEY_WK);
        wait_done(1'b0, l1, l2);
        check("weak_enc1", bus1.encrypted, CT_WK);
        check("weak_lat1", 64'(l1), 64'd16);
        check("weak_enc2", bus2.encrypted, CT_WK);
        do_ack("weak_ack");
        @(posedge clk); #1;

        // Random round trips through the reference decryptor
        for (int unsigned i = 0; i < 8; i++) begin
            m = {$urandom, $urandom};
            k = {$urandom, $urandom};
            start(m, k);
            wait_done(1'b0, l1, l2);
            check("rt_dec1", ref_decrypt(bus1.encrypted, k), m);
            check("rt_dec2", ref_decrypt(bus2.encrypted, k), m);
            do_ack("rt_ack");
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
